dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data-memory controller; successor to the single-cycle behavioural dmem. Adds a valid/ready request/response handshake and configurable wait states. Supports byte/half/word (and double for N=64) stores with byte-lane writes, and sign- or zero-extended loads. Reports faults for misaligned and out-of-range accesses. Sits between the CPU memory stage and the on-chip data array.

Parameters:
N, 32, data width in bits; power of two, >= 32; byte lanes L = N/8, offset bits OB = $clog2(L)
R, 6, word-address bits; depth = 2**R words of N bits
WAIT, 1, wait states between accept and response (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word(32b), 11 double (legal only when N=64)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
addr  input  N  byte address
writedata  input  N  store data, right-justified
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
readdata  output  N  load result (extended); 0 for stores and faults
fault  output  1  qualified by rsp_valid: misaligned, out of range, or illegal size

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, wait counter 0, req_ready=0 during reset, rsp_valid=0, readdata=0, fault=0. Memory array is not cleared.
- FSM states and transitions:
  - IDLE: req_ready=1. Accept on req_valid && req_ready; latch all request fields. Go to BUSY if WAIT>0, else RESP.
  - BUSY: counter counts WAIT-1 down to 0; req_ready=0. At 0, go to RESP.
  - RESP: rsp_valid=1; readdata and fault are held stable. On rsp_ready, return to IDLE.
- Latency: rsp_valid rises exactly WAIT+1 cycles after the accept edge. Minimum request spacing is WAIT+2 cycles; no overlap or pipelining.
- Commit point: the store write and the load array read occur on the edge entering RESP.
  - Reset before that edge abandons the operation; memory is unchanged.
  - Reset while in RESP drops the response.
- Word index = addr[R+OB-1:OB]; lane = addr[OB-1:0].
- Store: writes size bytes at lane from writedata[size*8-1:0]. All other lanes are preserved.
- Load: extracts size bytes at lane, then sign- or zero-extends to N per req_unsigned.
- Fault conditions (checked on the latched request):
  - addr not aligned to the access size;
  - any addr bit >= R+OB set;
  - size 11 with N=32.
- Fault effects: no write, readdata=0, fault=1, same latency as a normal access.
- Inputs are ignored outside IDLE. The latched copy isolates the operation from input changes mid-operation.

Decomposition:
- Package dmem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - state_e enum (IDLE, BUSY, RESP);
  - function lane_mask(size, lane) giving the byte-enable vector;
  - function extend(data, size, unsigned).
- Sub-module dmem_array: N-bit x 2**R, per-byte write enable, synchronous write, combinational read, no reset.
- dmem_ctrl contains the FSM, latches, fault checking and lane steering.

Test Plan:
- (N=32, R=6, WAIT=1 throughout.) Hold rst_n=0 for 2 cycles -> req_ready=0, rsp_valid=0, readdata=0, fault=0. Release -> req_ready=1 on the next cycle.
- sw 0xFFFFFFFF @0x00, then lw @0x00 -> rsp_valid exactly 2 cycles after each accept; readdata=0xFFFFFFFF; fault=0.
- sw 0x0000FFFF @0x04, sb 0x80 @0x05:
  - lw @0x04 = 0x000080FF;
  - lb @0x05 = 0xFFFFFF80;
  - lbu @0x05 = 0x00000080;
  - lh @0x04 = 0xFFFF80FF;
  - lhu @0x04 = 0x000080FF.
- Faults:
  - sw 0x12345678 @0x02 -> fault=1, readdata=0; lw @0x00 still returns 0xFFFFFFFF.
  - lw @0x100 -> fault=1.
  - size=11 -> fault=1.
- Hold rsp_ready=0 for 3 cycles on lw @0x04 -> rsp_valid, readdata and fault stay stable; req_ready=0. A new req_valid in that window is not accepted.
- Accept sw 0xDEADBEEF @0x08 (word previously 0), assert rst_n=0 during BUSY -> FSM returns to IDLE; a later lw @0x08 returns 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_pkg: shared types and lane helpers for the data-memory controller
// Rev 1.0
// ------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Helpers are sized for the widest supported word (64 bits, 8 lanes).
  localparam int MAX_W = 64;
  localparam int MAX_L = 8;

  function automatic logic [MAX_L-1:0] lane_mask(input size_e size, input logic [2:0] lane);
    logic [MAX_L-1:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lane;
  endfunction

  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] data, input size_e size,
                                              input logic is_unsigned);
    logic [MAX_W-1:0] r;
    case (size)
      SZ_B:    r = {{56{~is_unsigned & data[7]}},  data[7:0]};
      SZ_H:    r = {{48{~is_unsigned & data[15]}}, data[15:0]};
      SZ_W:    r = {{32{~is_unsigned & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_array: N-bit x 2**R storage, byte-lane synchronous write, async read
// Rev 1.0
// ------------------------------------------------------------------
module dmem_array #(
  parameter int N = 32,
  parameter int R = 6
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [N/8-1:0] be_i,
  input  logic [R-1:0]   addr_i,
  input  logic [N-1:0]   wdata_i,
  output logic [N-1:0]   rdata_o
);

  localparam int L = N / 8;

  logic [N-1:0] mem_q [2**R];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < L; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_ctrl: valid/ready data-memory controller with wait states and faults
// Rev 1.0
// ------------------------------------------------------------------
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int N    = 32,
  parameter int R    = 6,
  parameter int WAIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] writedata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] readdata,
  output logic         fault
);

  localparam int L  = N / 8;
  localparam int OB = $clog2(L);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rdy_en_q;
  logic         we_q, uns_q;
  size_e        size_q;
  logic [N-1:0] addr_q, wdata_q;
  logic [N-1:0] rdata_q;
  logic         fault_q;

  logic         w_accept, w_enter_resp, w_commit;
  logic         w_we, w_uns;
  size_e        w_size;
  logic [N-1:0] w_addr, w_wdata;
  logic [OB-1:0] w_lane, w_align;
  logic         w_misalign, w_oor, w_badsz, w_fault;
  logic [N-1:0] w_rdword, w_load;

  assign req_ready = rdy_en_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign readdata  = rdata_q;
  assign fault     = fault_q;
  assign w_accept  = req_valid && req_ready;

  // With WAIT=0 the commit edge is the accept edge, so the live inputs stand in for the latches.
  assign w_we    = (state_q == IDLE) ? req_we             : we_q;
  assign w_size  = (state_q == IDLE) ? size_e'(req_size)  : size_q;
  assign w_uns   = (state_q == IDLE) ? req_unsigned       : uns_q;
  assign w_addr  = (state_q == IDLE) ? addr               : addr_q;
  assign w_wdata = (state_q == IDLE) ? writedata          : wdata_q;
  assign w_lane  = w_addr[OB-1:0];

  always_comb begin
    case (w_size)
      SZ_B:    w_align = OB'(3'd0);
      SZ_H:    w_align = OB'(3'd1);
      SZ_W:    w_align = OB'(3'd3);
      default: w_align = OB'(3'd7);
    endcase
  end

  assign w_misalign = |(w_lane & w_align);
  assign w_badsz    = (N < 64) && (w_size == SZ_D);
  assign w_fault    = w_misalign | w_oor | w_badsz;

  if (R + OB < N) begin : g_range
    assign w_oor = |w_addr[N-1:R+OB];
  end else begin : g_norange
    assign w_oor = 1'b0;
  end

  assign w_load = N'(extend(64'(w_rdword >> {w_lane, 3'b000}), w_size, w_uns));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (WAIT == 0) begin
            state_d      = RESP;
            w_enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign w_commit = rst_n && w_enter_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdy_en_q <= 1'b0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      if (w_accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= size_e'(req_size);
        addr_q  <= addr;
        wdata_q <= writedata;
      end
      if (w_enter_resp) begin
        fault_q <= w_fault;
        rdata_q <= (w_fault || w_we) ? '0 : w_load;
      end
    end
  end

  dmem_array #(
    .N(N),
    .R(R)
  ) u_array (
    .clk    (clk),
    .we_i   (w_commit && w_we && !w_fault),
    .be_i   (L'(lane_mask(w_size, 3'(w_lane)))),
    .addr_i (w_addr[R+OB-1:OB]),
    .wdata_i(w_wdata << {w_lane, 3'b000}),
    .rdata_o(w_rdword)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl (N=32, R=6, WAIT=1)
// Rev 1.0
// ------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int N    = 32;
  localparam int R    = 6;
  localparam int WAIT = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [1:0]   req_size = 2'b10;
  logic         req_unsigned = 1'b0;
  logic [N-1:0] addr = '0;
  logic [N-1:0] writedata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] readdata;
  logic         fault;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sent = 0;
  int   rsp_cnt = 0;
  logic prev_v = 1'b0;
  exp_t mon_e;
  int   mon_a;

  dmem_ctrl #(.N(N), .R(R), .WAIT(WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .addr        (addr),
    .writedata   (writedata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .readdata    (readdata),
    .fault       (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: latency on each rising rsp_valid, data/fault on each response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && !prev_v) begin
        if (acc_q.size() == 0) chk("latency_unexpected", 32'd1, 32'd0);
        else begin
          mon_a = acc_q.pop_front();
          chk("latency", 32'(cyc - mon_a), 32'(WAIT + 1));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.nm, " data"}, readdata, mon_e.rd);
          chk({mon_e.nm, " fault"}, 32'(fault), 32'(mon_e.f));
        end
        rsp_cnt++;
      end
    end
    prev_v = rst_n && rsp_valid;
  end

  task automatic push_exp(input string nm, input logic [31:0] erd, input logic ef);
    exp_t e;
    e.rd = erd;
    e.f  = ef;
    e.nm = nm;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    sent++;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    addr         = a;
    writedata    = wd;
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    @(posedge clk); #1;
    while (req_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (rsp_cnt != sent && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, " done"}, 32'(rsp_cnt == sent), 32'd1);
  endtask

  task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic ef);
    wait_ready(nm);
    if (req_ready === 1'b1) begin
      drive(we, sz, uns, a, wd);
      push_exp(nm, erd, ef);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_done(nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset readdata", readdata, 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release req_ready", 32'(req_ready), 32'd1);

    do_req("sw ffffffff@0", 1'b1, 2'b10, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b0);
    do_req("lw @0",         1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hFFFFFFFF, 1'b0);
    do_req("sw 0000ffff@4", 1'b1, 2'b10, 1'b0, 32'h04, 32'h0000FFFF, 32'h0, 1'b0);
    do_req("sb 80@5",       1'b1, 2'b00, 1'b0, 32'h05, 32'h00000080, 32'h0, 1'b0);
    do_req("lw @4",         1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h000080FF, 1'b0);
    do_req("lb @5",         1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("lbu @5",        1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 32'h00000080, 1'b0);
    do_req("lh @4",         1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'hFFFF80FF, 1'b0);
    do_req("lhu @4",        1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 32'h000080FF, 1'b0);

    do_req("sw misaligned@2", 1'b1, 2'b10, 1'b0, 32'h02, 32'h12345678, 32'h0, 1'b1);
    do_req("lw @0 after fault", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hFFFFFFFF, 1'b0);
    do_req("lw range@100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    do_req("ld size11",     1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);

    // Back-pressure: response held with rsp_ready low while a new request is offered.
    rsp_ready = 1'b0;
    wait_ready("hold lw @4");
    drive(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    push_exp("hold lw @4", 32'h000080FF, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hold valid seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 2'b10, 1'b0, 32'h0C, 32'h55555555);
      @(negedge clk);
      chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold readdata", readdata, 32'h000080FF);
      chk("hold fault", 32'(fault), 32'd0);
      chk("hold req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done("hold lw @4");

    // Reset during BUSY abandons the store.
    do_req("sw 0@8", 1'b1, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    wait_ready("abort sw");
    drive(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort rsp_valid later", 32'(rsp_valid), 32'd0);
    do_req("lw @8 after abort", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
